// File: rtl/uart_io.sv
// UART serial I/O controller: CPU valid/ready byte ports, 8N1 framing,
// 16-deep (by default) TX and RX FIFOs and sticky line/buffer error flags.
module uart_io #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] in_data,
  output logic       in_vld,
  input  logic       in_rdy,
  input  logic [7:0] out_data,
  input  logic       out_vld,
  output logic       out_rdy,
  input  logic       err_clr,
  output logic [4:0] err
);

  localparam int            CW        = $clog2(CLK_PER_BIT);
  localparam int            DEPTH     = 1 << FIFO_AW;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wr;
  logic [FIFO_AW:0] tx_rd;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;
  tx_state_t        tx_state;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[FIFO_AW] != tx_rd[FIFO_AW]) &&
                    (tx_wr[FIFO_AW-1:0] == tx_rd[FIFO_AW-1:0]);
  assign out_rdy  = !tx_full;
  assign tx_push  = out_vld && !tx_full;
  assign tx_pop   = (tx_state == T_IDLE) && !tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[FIFO_AW-1:0]] <= out_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= tx_mem[tx_rd[FIFO_AW-1:0]];
            tx_cnt   <= BIT_LAST;
            uart_tx  <= 1'b0;
            tx_state <= T_START;
          end
        end
        T_START: begin
          if (tx_cnt == '0) begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            tx_state <= T_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        T_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= T_STOP;
            end else begin
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        T_STOP: begin
          if (tx_cnt == '0) tx_state <= T_IDLE;
          else              tx_cnt   <= tx_cnt - 1'b1;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // ---------------- RX synchroniser ----------------
  logic rx_s1;
  logic rx_s2;
  logic rx_prev;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] rx_wr;
  logic [FIFO_AW:0] rx_rd;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;
  logic [7:0]       rx_shift;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[FIFO_AW] != rx_rd[FIFO_AW]) &&
                    (rx_wr[FIFO_AW-1:0] == rx_rd[FIFO_AW-1:0]);
  assign in_vld   = !rx_empty;
  assign rx_pop   = in_vld && in_rdy;
  // Head is masked while empty so in_data reads zero out of reset.
  assign in_data  = rx_empty ? '0 : rx_mem[rx_rd[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[FIFO_AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_tick;
  logic          stop_hit;
  logic          ev_framing;
  logic          ev_overflow;
  logic          ev_false_start;

  assign rx_tick        = (rx_cnt == '0);
  assign stop_hit       = (rx_state == R_STOP) && rx_tick;
  assign ev_false_start = (rx_state == R_START) && rx_tick && rx_s2;
  assign ev_framing     = stop_hit && !rx_s2;
  // A same-cycle pop frees a slot in a full FIFO, so the byte still lands.
  assign rx_push        = stop_hit && rx_s2 && (!rx_full || rx_pop);
  assign ev_overflow    = stop_hit && rx_s2 && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (rx_tick) begin
            if (rx_s2) begin
              rx_state <= R_IDLE;
            end else begin
              rx_cnt   <= BIT_LAST;
              rx_bit   <= '0;
              rx_state <= R_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_bit == 3'd7) rx_state <= R_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        R_STOP: begin
          if (rx_tick) rx_state <= R_IDLE;
          else         rx_cnt   <= rx_cnt - 1'b1;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- Sticky errors ----------------
  logic [2:0] err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      err_q <= (err_q & {3{~err_clr}}) | {ev_false_start, ev_overflow, ev_framing};
    end
  end

  assign err = {2'b00, err_q};

endmodule

// File: tb/tb_uart_io.sv
// Scoreboard bench for uart_io: TX frames decoded off uart_tx, RX bytes
// popped from the CPU port, both matched against queued expectations.
module tb_uart_io;

  localparam int CPB = 16;
  localparam int AW  = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       uart_rx;
  logic       uart_tx;
  logic [7:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       err_clr;
  logic [4:0] err;

  logic rx_drv;
  logic loopback;
  assign uart_rx = loopback ? uart_tx : rx_drv;

  uart_io #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .in_data  (in_data),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .err_clr  (err_clr),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         tx_starts[$];
  int         rx_pops = 0;
  int         n_accepts = 0;
  int         rdy_drop_at = -1;
  int         last_push_cyc = 0;
  bit         rdy_low_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_push(input logic [7:0] b, input bit also_rx);
    int t;
    t = 0;
    out_data = b;
    out_vld  = 1'b1;
    forever begin
      @(negedge clk);
      if (out_rdy) break;
      if (rdy_drop_at < 0) rdy_drop_at = n_accepts;
      t++;
      if (t > 4000) begin
        check("tx_push_timeout", 32'(t), 0);
        out_vld = 1'b0;
        return;
      end
    end
    tx_q.push_back(b);
    if (also_rx) rx_q.push_back(b);
    last_push_cyc = cyc;
    n_accepts++;
    @(posedge clk);
    #1;
    out_vld = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input bit expect_byte);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (expect_byte) rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      step(CPB);
    end
    rx_drv = 1'b1;
    step(4);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && t < 5000) begin
      step(1);
      t++;
    end
    check(tag, 32'(t < 5000), 1);
    step(4);
  endtask

  // TX monitor: decode one frame sample-by-sample; every bit must hold CPB cycles.
  initial begin : tx_mon
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit         glitch;
    bit         abort;
    int         t0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && uart_tx === 1'b0) begin
        t0 = cyc;
        glitch = 0;
        abort = 0;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (!rstn) abort = 1;
            if (s == 0) bits[b] = uart_tx;
            else if (uart_tx !== bits[b]) glitch = 1;
          end
        end
        if (tx_q.size() == 0) begin
          check("tx_unexpected_frame", 32'(tx_q.size()), 1);
        end else begin
          exp_b = tx_q.pop_front();
          if (!abort) begin
            tx_starts.push_back(t0);
            check("tx_data", 32'(bits[8:1]), 32'(exp_b));
            check("tx_start_stop", 32'({bits[9], bits[0]}), 32'b10);
            check("tx_bit_width", 32'(glitch), 0);
          end
        end
      end
    end
  end

  // RX monitor: every CPU pop is matched against the head of rx_q.
  always @(negedge clk) begin
    if (rstn === 1'b1 && in_vld && in_rdy) begin
      rx_pops++;
      if (rx_q.size() == 0) check("rx_unexpected_pop", 32'(rx_q.size()), 1);
      else                  check("rx_data", 32'(in_data), 32'(rx_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rstn === 1'b1 && !out_rdy) rdy_low_seen = 1;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] fr;
    int         pops0;

    rstn = 1'b0; in_rdy = 1'b0; out_vld = 1'b0; out_data = '0;
    err_clr = 1'b0; rx_drv = 1'b1; loopback = 1'b0;
    step(3);
    rstn = 1'b1;
    check("rst_uart_tx", 32'(uart_tx), 1);
    check("rst_in_vld",  32'(in_vld), 0);
    check("rst_in_data", 32'(in_data), 0);
    check("rst_out_rdy", 32'(out_rdy), 1);
    check("rst_err",     32'(err), 0);
    step(2);

    // TX single byte: line low 2 cycles after the accepting edge.
    tx_starts.delete();
    rdy_low_seen = 0;
    tx_push(8'hA5, 0);
    wait_drain("tx_single_drain");
    check("tx_single_frames", 32'(tx_starts.size()), 1);
    if (tx_starts.size() > 0) check("tx_single_latency", 32'(tx_starts[0] - last_push_cyc), 2);
    check("tx_single_rdy_stayed_high", 32'(rdy_low_seen), 0);

    // Backpressure: first byte moves straight into the shifter, so
    // 2**AW + 1 accepts happen before out_rdy first drops.
    tx_starts.delete();
    n_accepts = 0;
    rdy_drop_at = -1;
    for (int i = 0; i < 6; i++) tx_push(8'(8'h31 + 8'(i * 17)), 0);
    wait_drain("tx_bp_drain");
    check("tx_bp_rdy_drop", 32'(rdy_drop_at), 32'((1 << AW) + 1));
    check("tx_bp_frames", 32'(tx_starts.size()), 6);
    for (int i = 1; i < tx_starts.size(); i++)
      check("tx_bp_spacing", 32'(tx_starts[i] - tx_starts[i-1]), 10 * CPB + 1);

    // Loopback.
    loopback = 1'b1;
    in_rdy = 1'b1;
    pops0 = rx_pops;
    tx_push(8'h00, 1);
    tx_push(8'hFF, 1);
    tx_push(8'h3C, 1);
    wait_drain("loop_drain");
    loopback = 1'b0;
    step(2);
    check("loop_pops", 32'(rx_pops - pops0), 3);
    check("loop_err", 32'(err), 0);

    // RX overflow: five frames into a four-entry FIFO with no pops.
    in_rdy = 1'b0;
    pops0 = rx_pops;
    rx_send(8'h11, 1'b1, 1);
    rx_send(8'h22, 1'b1, 1);
    rx_send(8'h33, 1'b1, 1);
    rx_send(8'h44, 1'b1, 1);
    rx_send(8'h55, 1'b1, 0);
    check("ovf_in_vld", 32'(in_vld), 1);
    check("ovf_err", 32'(err), 32'b00010);
    in_rdy = 1'b1;
    wait_drain("ovf_drain");
    step(10);
    check("ovf_pops", 32'(rx_pops - pops0), 4);
    check("ovf_err_sticky", 32'(err), 32'b00010);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("ovf_err_cleared", 32'(err), 0);

    // Framing error then false start.
    rx_send(8'h77, 1'b0, 0);
    step(4);
    check("frm_err", 32'(err), 32'b00001);
    check("frm_in_vld", 32'(in_vld), 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    rx_drv = 1'b0;
    step(4);
    rx_drv = 1'b1;
    step(24);
    check("fs_err", 32'(err), 32'b00100);
    check("fs_in_vld", 32'(in_vld), 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("fs_err_cleared", 32'(err), 0);

    // Reset mid-frame: TX in data bit 3, RX in data bit 5 at cycle 100.
    pops0 = rx_pops;
    fr = {1'b1, 8'hC3, 1'b0};
    for (int k = 0; k <= 100; k++) begin
      rx_drv  = fr[k / CPB];
      out_vld = 1'b0;
      if (k == 30) begin
        out_data = 8'h96;
        out_vld  = 1'b1;
        tx_q.push_back(8'h96);
      end
      if (k == 100) begin
        rstn   = 1'b0;
        rx_drv = 1'b1;
      end
      step(1);
    end
    rstn = 1'b1;
    check("mid_rst_uart_tx", 32'(uart_tx), 1);
    check("mid_rst_in_vld",  32'(in_vld), 0);
    check("mid_rst_err",     32'(err), 0);
    check("mid_rst_out_rdy", 32'(out_rdy), 1);
    rx_send(8'h5A, 1'b1, 1);
    wait_drain("mid_rst_drain");
    check("mid_rst_pops", 32'(rx_pops - pops0), 1);
    check("mid_rst_err_after", 32'(err), 0);

    check("tx_q_left", 32'(tx_q.size()), 0);
    check("rx_q_left", 32'(rx_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
